// File: rtl/vga_timing.sv
// vga_timing: raster timing generator for a VGA-style display pipeline.
//
// Free-running horizontal/vertical counters advance on each clock edge with en=1.
// The counters are exposed as x/y for the display stage.
// Sync and blanking are derived from the counters.
// They are then delayed by SYNC_DELAY cycles so they line up with the downstream pixel lookup.
//
// Ports:
//   clk          pixel clock
//   rst_n        synchronous active-low reset
//   en           pixel advance enable
//   x [10:0]     current column (hcount); x[10]=1 during horizontal blanking
//   y [10:0]     current row; y[10]=1 throughout vertical blanking
//   hsync/vsync  delayed sync pulses, active level set by SYNC_POL
//   blank        delayed active-high blanking
//   frame_start  one-cycle pulse at (0,0) when en=1, aligned to x/y (undelayed)
module vga_timing #(
  parameter int unsigned H_ACTIVE   = 1024,
  parameter int unsigned H_FP       = 24,
  parameter int unsigned H_SYNC     = 136,
  parameter int unsigned H_BP       = 160,
  parameter int unsigned V_ACTIVE   = 768,
  parameter int unsigned V_FP       = 3,
  parameter int unsigned V_SYNC     = 6,
  parameter int unsigned V_BP       = 29,
  parameter int unsigned SYNC_POL   = 0,
  parameter int unsigned SYNC_DELAY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        frame_start
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] HLast      = 11'(HTotal - 1);
  localparam logic [10:0] VLast      = 11'(VTotal - 1);
  localparam logic [10:0] HActive    = 11'(H_ACTIVE);
  localparam logic [10:0] VActive    = 11'(V_ACTIVE);
  localparam logic [10:0] HSyncStart = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HSyncEnd   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VSyncStart = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VSyncEnd   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        ActiveHigh = (SYNC_POL != 0);

  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;

  // Counter next state: vcount only moves on the edge where hcount wraps.
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (en) begin
      if (hcount_q == HLast) begin
        hcount_d = 11'd0;
        vcount_d = (vcount_q == VLast) ? 11'd0 : vcount_q + 11'd1;
      end else begin
        hcount_d = hcount_q + 11'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcount_q <= 11'd0;
      vcount_q <= 11'd0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  assign x = hcount_q;
  // Force bit 10 in vertical blanking so consumers can test a single bit.
  assign y = (vcount_q < VActive) ? vcount_q : {1'b1, vcount_q[9:0]};

  assign frame_start = en && (hcount_q == 11'd0) && (vcount_q == 11'd0);

  // Undelayed timing, active-high: {hsync, vsync, blank}.
  logic       hs_raw, vs_raw, bl_raw;
  logic [2:0] raw, dly;

  assign hs_raw = (hcount_q >= HSyncStart) && (hcount_q < HSyncEnd);
  assign vs_raw = (vcount_q >= VSyncStart) && (vcount_q < VSyncEnd);
  assign bl_raw = (hcount_q >= HActive) || (vcount_q >= VActive);
  assign raw    = {hs_raw, vs_raw, bl_raw};

  // The delay line runs every cycle, independent of en, so its latency stays fixed in clocks.
  // Polarity is applied after the delay, so the reset value means "sync inactive, blanked".
  if (SYNC_DELAY == 0) begin : g_no_delay
    assign dly = raw;
  end else begin : g_delay
    logic [2:0] pipe_q [SYNC_DELAY];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(SYNC_DELAY); i++) begin
          pipe_q[i] <= 3'b001;
        end
      end else begin
        pipe_q[0] <= raw;
        for (int i = 1; i < int'(SYNC_DELAY); i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end
    end

    assign dly = pipe_q[SYNC_DELAY-1];
  end

  assign hsync = ActiveHigh ? dly[2] : ~dly[2];
  assign vsync = ActiveHigh ? dly[1] : ~dly[1];
  assign blank = dly[0];

endmodule
